// File: rtl/dll_pkg.sv
// Shared state encoding and counter constants for the DLL lock monitor.
package dll_pkg;

    localparam int CNT_W   = 7;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        TRACK  = 2'd2,
        LOCKED = 2'd3
    } dll_state_t;

endpackage

// File: rtl/osc_edge_sync.sv
// Two-flop synchronizer plus delay flop; emits a one-cycle pulse per rising
// edge of an asynchronous input.
module osc_edge_sync (
    input  logic clock,
    input  logic resetb,
    input  logic i_async,
    output logic o_edge
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_edge = r_s2 & ~r_s3;

endmodule

// File: rtl/dll_lock_detect.sv
// DLL lock monitor: measures each reference period in DLL clocks, compares it
// with the feedback ratio and tracks lock / loss of reference.
module dll_lock_detect #(
    parameter int CNT_W      = dll_pkg::CNT_W,
    parameter int LOCK_COUNT = 16,
    parameter int LOSS_COUNT = 2
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             enable,
    input  logic             osc,
    input  logic [4:0]       div,
    input  logic [2:0]       tol,
    output logic             locked,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             too_fast,
    output logic             too_slow,
    output logic             osc_lost
);

    import dll_pkg::*;

    // CNT_SAT is sized for the package width; override both together.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_SAT);
    localparam logic [4:0]       LOCK_N  = 5'(LOCK_COUNT);
    localparam logic [4:0]       LOSS_N  = 5'(LOSS_COUNT);

    dll_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0]  r_period, w_period_nxt;
    logic [4:0]        r_good_cnt, w_good_cnt_nxt;
    logic [4:0]        r_bad_cnt, w_bad_cnt_nxt;
    logic              r_period_valid, w_period_valid_nxt;
    logic              r_too_fast, w_too_fast_nxt;
    logic              r_too_slow, w_too_slow_nxt;
    logic              r_osc_lost, w_osc_lost_nxt;

    logic              w_edge;
    logic              w_sat;
    logic              w_fast;
    logic              w_slow;
    logic              w_good;
    logic [4:0]        w_good_inc;
    logic [4:0]        w_bad_inc;
    logic signed [CNT_W:0] w_err;
    logic signed [CNT_W:0] w_tol;

    osc_edge_sync u_osc_sync (
        .clock   (clock),
        .resetb  (resetb),
        .i_async (osc),
        .o_edge  (w_edge)
    );

    assign w_err      = $signed({1'b0, r_cnt}) - $signed({{(CNT_W-4){1'b0}}, div});
    assign w_tol      = $signed({{(CNT_W-2){1'b0}}, tol});
    assign w_fast     = w_err > w_tol;
    assign w_slow     = w_err < -w_tol;
    assign w_good     = !w_fast && !w_slow && (div != 5'd0);
    assign w_good_inc = r_good_cnt + 5'd1;
    assign w_bad_inc  = r_bad_cnt + 5'd1;
    // An edge coinciding with saturation is a valid 127-cycle period, not a loss.
    assign w_sat      = (r_cnt == CNT_MAX) && !w_edge;

    // NOTE: every register here updates with <= so all of them sample the
    // pre-edge values computed below; the file holds no memory arrays, so each
    // flop takes the asynchronous reset.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_period       <= '0;
            r_good_cnt     <= '0;
            r_bad_cnt      <= '0;
            r_period_valid <= 1'b0;
            r_too_fast     <= 1'b0;
            r_too_slow     <= 1'b0;
            r_osc_lost     <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_period       <= w_period_nxt;
            r_good_cnt     <= w_good_cnt_nxt;
            r_bad_cnt      <= w_bad_cnt_nxt;
            r_period_valid <= w_period_valid_nxt;
            r_too_fast     <= w_too_fast_nxt;
            r_too_slow     <= w_too_slow_nxt;
            r_osc_lost     <= w_osc_lost_nxt;
        end
    end

    // NOTE: defaults at the top of each always_comb keep every path assigned,
    // so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = ARM;
                ARM:     if (w_edge) w_state_nxt = TRACK;
                TRACK:   if (w_edge && w_good && w_good_inc == LOCK_N) w_state_nxt = LOCKED;
                LOCKED:  if (w_edge && !w_good && w_bad_inc == LOSS_N) w_state_nxt = TRACK;
                default: w_state_nxt = IDLE;
            endcase
            if (r_state != IDLE && w_sat) w_state_nxt = ARM;
        end
    end

    always_comb begin
        w_cnt_nxt          = r_cnt;
        w_period_nxt       = r_period;
        w_period_valid_nxt = 1'b0;
        w_too_fast_nxt     = r_too_fast;
        w_too_slow_nxt     = r_too_slow;
        w_osc_lost_nxt     = r_osc_lost;
        w_good_cnt_nxt     = r_good_cnt;
        w_bad_cnt_nxt      = r_bad_cnt;

        if (!enable || r_state == IDLE) begin
            w_cnt_nxt      = '0;
            w_period_nxt   = '0;
            w_too_fast_nxt = 1'b0;
            w_too_slow_nxt = 1'b0;
            w_osc_lost_nxt = 1'b0;
            w_good_cnt_nxt = '0;
            w_bad_cnt_nxt  = '0;
        end else begin
            if (w_edge) begin
                w_cnt_nxt = CNT_W'(1);
            end else if (r_cnt != CNT_MAX) begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end

            if (w_edge) begin
                w_osc_lost_nxt = 1'b0;
                // The first edge after arming only starts the count.
                if (r_state != ARM) begin
                    w_period_nxt       = r_cnt;
                    w_period_valid_nxt = 1'b1;
                    w_too_fast_nxt     = w_fast;
                    w_too_slow_nxt     = w_slow;
                end
                if (r_state == TRACK) begin
                    w_bad_cnt_nxt  = '0;
                    w_good_cnt_nxt = (w_good && w_good_inc != LOCK_N) ? w_good_inc : '0;
                end else if (r_state == LOCKED) begin
                    w_good_cnt_nxt = '0;
                    w_bad_cnt_nxt  = (!w_good && w_bad_inc != LOSS_N) ? w_bad_inc : '0;
                end
            end else if (w_sat) begin
                w_osc_lost_nxt = 1'b1;
                w_good_cnt_nxt = '0;
                w_bad_cnt_nxt  = '0;
            end
        end
    end

    assign locked       = (r_state == LOCKED);
    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign too_fast     = r_too_fast;
    assign too_slow     = r_too_slow;
    assign osc_lost     = r_osc_lost;

endmodule

// File: tb/tb_dll_lock_detect.sv
// Bench for dll_lock_detect: directed phases plus randomized periods, every
// cycle compared against a period-level reference model.
module tb_dll_lock_detect;

    localparam int CNT_W    = 7;
    localparam int SAT      = 127;
    localparam int LOCK_N   = 16;
    localparam int LOSS_N   = 2;
    localparam int M_IDLE   = 0;
    localparam int M_ARM    = 1;
    localparam int M_TRACK  = 2;
    localparam int M_LOCKED = 3;

    logic             clock = 1'b0;
    logic             resetb;
    logic             enable;
    logic             osc;
    logic [4:0]       div;
    logic [2:0]       tol;
    logic             locked;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             too_fast;
    logic             too_slow;
    logic             osc_lost;

    dll_lock_detect dut (
        .clock        (clock),
        .resetb       (resetb),
        .enable       (enable),
        .osc          (osc),
        .div          (div),
        .tol          (tol),
        .locked       (locked),
        .period       (period),
        .period_valid (period_valid),
        .too_fast     (too_fast),
        .too_slow     (too_slow),
        .osc_lost     (osc_lost)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model, in terms of the monitor's documented rules.
    int m_mode, m_cnt, m_good, m_bad, m_period;
    bit m_pv, m_tf, m_ts, m_lost;
    bit d1, d2, d3;   // osc as driven one, two and three clocks back

    // Observations gathered for the directed checks.
    int strobes, first_pv_period, first_lock_strobes, n10, drop_n10;
    bit dir_seen, lock_seen, locked_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_cnt = 0; m_good = 0; m_bad = 0; m_period = 0;
        m_pv = 0; m_tf = 0; m_ts = 0; m_lost = 0;
        d1 = 0; d2 = 0; d3 = 0;
    endtask

    task automatic model_step(input bit e);
        int  err;
        bit  good;
        m_pv = 0;
        if (!enable) begin
            m_mode = M_IDLE; m_cnt = 0; m_good = 0; m_bad = 0; m_period = 0;
            m_tf = 0; m_ts = 0; m_lost = 0;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_ARM;
            m_cnt  = 0;
        end else if (e) begin
            m_lost = 0;
            if (m_mode == M_ARM) begin
                m_mode = M_TRACK;
            end else begin
                err      = m_cnt - int'(div);
                m_period = m_cnt;
                m_pv     = 1;
                m_tf     = err > int'(tol);
                m_ts     = err < -int'(tol);
                good     = (div != 0) && !m_tf && !m_ts;
                if (m_mode == M_TRACK) begin
                    m_good = good ? m_good + 1 : 0;
                    if (m_good == LOCK_N) begin m_mode = M_LOCKED; m_good = 0; end
                end else begin
                    m_bad = good ? 0 : m_bad + 1;
                    if (m_bad == LOSS_N) begin m_mode = M_TRACK; m_bad = 0; end
                end
            end
            m_cnt = 1;
        end else if (m_cnt == SAT) begin
            m_mode = M_ARM; m_lost = 1; m_good = 0; m_bad = 0;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic compare_all();
        check("locked",       32'(locked),       32'(m_mode == M_LOCKED));
        check("period",       32'(period),       32'(m_period));
        check("period_valid", 32'(period_valid), 32'(m_pv));
        check("too_fast",     32'(too_fast),     32'(m_tf));
        check("too_slow",     32'(too_slow),     32'(m_ts));
        check("osc_lost",     32'(osc_lost),     32'(m_lost));
    endtask

    // One clock: drive osc at the falling edge, model the rising edge, compare.
    task automatic cycle(input bit osc_v);
        bit e;
        @(negedge clock);
        osc = osc_v;
        @(posedge clock);
        e  = d2 && !d3;   // rise becomes an edge three clocks after it is driven
        d3 = d2; d2 = d1; d1 = osc_v;
        model_step(e);
        #1;
        compare_all();
        if (period_valid === 1'b1) begin
            strobes++;
            if (first_pv_period < 0) first_pv_period = int'(period);
            if (period === 7'd10) n10++;
        end
        if (locked === 1'b1 && first_lock_strobes < 0) first_lock_strobes = strobes;
        if (locked_prev && locked === 1'b0 && drop_n10 < 0) drop_n10 = n10;
        if (too_fast === 1'b1 || too_slow === 1'b1) dir_seen = 1;
        if (locked === 1'b1) lock_seen = 1;
        locked_prev = (locked === 1'b1);
    endtask

    task automatic run_period(input int p);
        for (int i = 0; i < p; i++) cycle(i < (p + 1) / 2);
    endtask

    initial begin
        int p;
        int base;

        resetb = 1'b0; enable = 1'b0; osc = 1'b0; div = 5'd8; tol = 3'd0;
        model_reset();
        strobes = 0; first_pv_period = -1; first_lock_strobes = -1;
        n10 = 0; drop_n10 = -1; dir_seen = 0; lock_seen = 0; locked_prev = 0;
        #23;
        compare_all();
        resetb = 1'b1;
        cycle(0); cycle(0);

        // Lock at div=8, tol=0 with an exact 8-clock reference.
        enable = 1'b1;
        strobes = 0; first_pv_period = -1; first_lock_strobes = -1;
        for (int k = 0; k < 19; k++) run_period(8);
        check("first_period", 32'(first_pv_period), 32'd8);
        check("lock_strobe", 32'(first_lock_strobes), 32'd16);

        // Reference slows to 10 clocks: DLL runs fast, lock drops on 2nd strobe.
        n10 = 0; drop_n10 = -1;
        for (int k = 0; k < 4; k++) run_period(10);
        check("drop_strobe", 32'(drop_n10), 32'd2);
        check("dir_period", 32'(period), 32'd10);
        check("dir_too_fast", 32'(too_fast), 32'd1);

        // Tolerance 1 with alternating 7/9 periods.
        tol = 3'd1;
        run_period(7); run_period(9);
        dir_seen = 0;
        for (int k = 0; k < 19; k++) begin run_period(7); run_period(9); end
        check("tol_locked", 32'(locked), 32'd1);
        check("tol_no_dir", 32'(dir_seen), 32'd0);

        // Reference lost, then restarted.
        for (int k = 0; k < 140; k++) cycle(0);
        check("loss_flag", 32'(osc_lost), 32'd1);
        check("loss_unlock", 32'(locked), 32'd0);
        base = strobes;
        run_period(8);
        check("restart_clear", 32'(osc_lost), 32'd0);
        check("restart_no_strobe", 32'(strobes), 32'(base));
        for (int k = 0; k < 3; k++) run_period(8);

        // div = 0 never locks.
        div = 5'd0; tol = 3'($urandom_range(0, 7)); lock_seen = 0;
        for (int k = 0; k < 30; k++) run_period(int'($urandom_range(2, 20)));
        check("div0_no_lock", 32'(lock_seen), 32'd0);

        // Randomized ratios, tolerances and periods, including saturation.
        for (int t = 0; t < 6; t++) begin
            div = 5'($urandom_range(3, 25));
            tol = 3'($urandom_range(0, 7));
            enable = 1'b0; cycle(0); enable = 1'b1;
            for (int k = 0; k < 25; k++) begin
                if ($urandom_range(0, 7) == 0) p = 126 + int'($urandom_range(0, 2));
                else p = int'(div) + int'($urandom_range(0, 2 * int'(tol) + 2)) - (int'(tol) + 1);
                if (p < 2) p = 2;
                run_period(p);
            end
        end

        // Enable dropped while locked.
        div = 5'd8; tol = 3'd0;
        enable = 1'b0; cycle(0); enable = 1'b1;
        for (int k = 0; k < 20; k++) run_period(8);
        check("relock", 32'(locked), 32'd1);
        cycle(1); cycle(1); cycle(1);
        enable = 1'b0;
        cycle(1);
        check("en_locked", 32'(locked), 32'd0);
        check("en_period", 32'(period), 32'd0);
        check("en_osc_lost", 32'(osc_lost), 32'd0);
        enable = 1'b1;
        cycle(0);

        // Asynchronous reset mid-period.
        for (int k = 0; k < 20; k++) run_period(8);
        cycle(1); cycle(1);
        check("pre_rst_period", 32'(period), 32'd8);
        check("pre_rst_locked", 32'(locked), 32'd1);
        #2;
        resetb = 1'b0;
        #1;
        model_reset();
        compare_all();
        resetb = 1'b1;
        for (int k = 0; k < 20; k++) run_period(8);
        check("post_rst_lock", 32'(locked), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
